// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register controller: frame/response layouts and FSM states.
package spi_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Incoming command frame, bit 15 first
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Response frame shifted out during the following SPI frame
  typedef struct packed {
    logic              sticky_err;
    logic              bad_addr;
    logic              last_rw;
    logic [CNT_W-1:0]  frame_cnt;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: reg 0 is a read-only ID, regs 1..N-1 are writable from SPI (priority) or local port.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int unsigned       p_num_regs = 8,
  parameter logic [DATA_W-1:0] p_id       = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_we,
  input  logic [ADDR_W-1:0]            spi_addr,
  input  logic [DATA_W-1:0]            spi_wdata,
  input  logic                         loc_we,
  input  logic [ADDR_W-1:0]            loc_addr,
  input  logic [DATA_W-1:0]            loc_wdata,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data_c,
  output logic [DATA_W*p_num_regs-1:0] regs
);

  logic [DATA_W-1:0] regs_q [1:p_num_regs-1];

  // Only addresses 1..N-1 exist as storage, so writes to 0 or out of range fall through
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i < p_num_regs; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < p_num_regs; i++) begin
        if (spi_we && spi_addr == ADDR_W'(i))      regs_q[i] <= spi_wdata;
        else if (loc_we && loc_addr == ADDR_W'(i)) regs_q[i] <= loc_wdata;
      end
    end
  end

  always_comb begin
    regs             = '0;
    regs[DATA_W-1:0] = p_id;
    for (int unsigned i = 1; i < p_num_regs; i++) regs[DATA_W*i +: DATA_W] = regs_q[i];
  end

  always_comb begin
    rd_data_c = '0;
    if (rd_addr == '0) rd_data_c = p_id;
    for (int unsigned i = 1; i < p_num_regs; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data_c = regs_q[i];
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Decodes spi_slave frames into register reads/writes and loads the response for the next frame.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned       p_data_buffer_length  = 32,
  parameter int unsigned       p_width_buffer_length = 6,
  parameter int unsigned       p_num_regs            = 8,
  parameter logic [DATA_W-1:0] p_id                  = 8'hA5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [p_data_buffer_length-1:0]  ip_data_in,
  input  logic                             i_data_valid,
  input  logic                             i_error,
  output logic [p_data_buffer_length-1:0]  op_data_out,
  output logic [p_width_buffer_length-1:0] op_data_count,
  input  logic                             i_loc_valid,
  output logic                             o_loc_ready,
  input  logic [ADDR_W-1:0]                ip_loc_addr,
  input  logic [DATA_W-1:0]                ip_loc_wdata,
  output logic [DATA_W*p_num_regs-1:0]     op_regs,
  output logic [7:0]                       op_err_count
);

  state_t            state;
  cmd_t              cmd_q;
  logic              bad_q;
  logic              sticky_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic              spi_we_c;
  logic              loc_we_c;
  logic [DATA_W-1:0] rd_data_c;
  resp_t             resp_c;
  logic              unused_hi;

  assign op_data_count = p_width_buffer_length'(FRAME_LEN);
  assign unused_hi     = ^ip_data_in[p_data_buffer_length-1:FRAME_LEN];

  assign spi_we_c = (state == DECODE) && cmd_q.rw && !bad_q;
  assign loc_we_c = i_loc_valid && o_loc_ready;

  always_comb begin
    resp_c            = '0;
    resp_c.sticky_err = sticky_q;
    resp_c.bad_addr   = bad_q;
    resp_c.last_rw    = cmd_q.rw;
    resp_c.frame_cnt  = frame_cnt_q + CNT_W'(1);
    resp_c.data       = resp_data_q;
  end

  spi_reg_bank #(
    .p_num_regs (p_num_regs),
    .p_id       (p_id)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .spi_we    (spi_we_c),
    .spi_addr  (cmd_q.addr),
    .spi_wdata (cmd_q.wdata),
    .loc_we    (loc_we_c),
    .loc_addr  (ip_loc_addr),
    .loc_wdata (ip_loc_wdata),
    .rd_addr   (cmd_q.addr),
    .rd_data_c (rd_data_c),
    .regs      (op_regs)
  );

  // Frame sequencer; o_loc_ready is registered so it is low exactly while in DECODE/EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      bad_q        <= 1'b0;
      sticky_q     <= 1'b0;
      resp_data_q  <= '0;
      frame_cnt_q  <= '0;
      op_data_out  <= '0;
      op_err_count <= '0;
      o_loc_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_data_valid) begin
            if (i_error) begin
              sticky_q <= 1'b1;
              if (op_err_count != 8'hFF) op_err_count <= op_err_count + 8'd1;
            end else begin
              cmd_q <= cmd_t'(ip_data_in[FRAME_LEN-1:0]);
              state <= LATCH;
            end
          end
        end
        LATCH: begin
          bad_q       <= (8'(cmd_q.addr) >= 8'(p_num_regs)) || (cmd_q.rw && cmd_q.addr == '0);
          o_loc_ready <= 1'b0;
          state       <= DECODE;
        end
        DECODE: begin
          resp_data_q <= bad_q ? '0 : (cmd_q.rw ? cmd_q.wdata : rd_data_c);
          state       <= EXEC;
        end
        EXEC: begin
          o_loc_ready <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          frame_cnt_q <= resp_c.frame_cnt;
          op_data_out <= p_data_buffer_length'(resp_c);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
